fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the synchronous program ROM (cs/address in, data_out registered one clock later).
- Owns the program counter and drives the ROM chip-select and address.
- Captures the returned word into an instruction register.
- Presents the word to the decoder with a valid/ready handshake; supports PC redirect (jump) and halt detection.

Parameters:
ADDR_W, 4, PC / ROM address width; PC wraps modulo 2^ADDR_W
DATA_W, 8, instruction word width (matches ROM data width)
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 8'hFF, instruction word that stops fetching once accepted downstream

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  fetch enable; level-sensitive
mem_cs  output  1  ROM chip-select, combinational, high only in ISSUE
mem_addr  output  ADDR_W  ROM address, combinational, equals pc
mem_data  input  DATA_W  ROM data_out, valid the cycle after mem_cs was sampled high
instr  output  DATA_W  captured instruction word
instr_pc  output  ADDR_W  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decoder accepts when instr_valid & instr_ready at posedge
redirect  input  1  load redirect_pc into PC, squash in-flight work
redirect_pc  input  ADDR_W  jump target
halted  output  1  high in HALTED state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, issued_pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0. Hence mem_cs=0 and mem_addr=RESET_PC.
- States: IDLE, ISSUE, WAIT, OUT, HALTED. One instruction per 3 cycles minimum; no overlap of requests.
- IDLE: mem_cs=0. If run=1, go to ISSUE next cycle.
- ISSUE: mem_cs=1, mem_addr=pc. At the edge: issued_pc<=pc, pc<=pc+1 (2^ADDR_W-1 wraps to 0), go to WAIT. The run value is ignored once ISSUE is entered.
- WAIT: mem_cs=0; mem_data holds the word for issued_pc. At the edge: instr<=mem_data, instr_pc<=issued_pc, instr_valid<=1, go to OUT.
- OUT: instr_valid=1; instr and instr_pc are held stable until accepted. On accept:
  - instr_valid<=0.
  - If instr==HALT_OPCODE: go to HALTED, halted<=1.
  - Else if run: go to ISSUE.
  - Else: go to IDLE.
- HALTED: mem_cs=0, instr_valid=0, halted=1. Exits only on reset or redirect.
- Redirect (any state, highest priority, synchronous):
  - pc<=redirect_pc, instr_valid<=0, halted<=0.
  - Next state is ISSUE if run=1, else IDLE.
  - In WAIT, the returning mem_data is discarded; instr is not updated.
  - In OUT, a simultaneous instr_ready does not count as an accept; the word is squashed.
  - In ISSUE, the ROM still performs the read (mem_cs already high), but the result is ignored.
- run falling mid-transaction: the ISSUE/WAIT/OUT sequence completes normally, then the block goes to IDLE after accept. pc then points to the next unfetched address.
- instr_ready while instr_valid=0 has no effect.
- Halt word: delivered to the decoder like any other instruction (instr_valid=1) before halting.
- No combinational path from instr_ready to mem_cs.

Test Plan:
- ROM = {0x11,0x22,0x33,...}, run=1, ready=1 after reset release -> mem_cs pulses at cycles 1,4,7. instr/instr_pc = (0x11,0),(0x22,1),(0x33,2), each instr_valid for 1 cycle.
- Backpressure: ready=0 for 5 cycles while instr_valid=1 -> instr, instr_pc and instr_valid stable, mem_cs=0 throughout. On ready=1, the next ISSUE follows the accept cycle.
- Wrap: RESET_PC=14, ROM[14]=0xAE, ROM[15]=0xAF, ROM[0]=0xA0 -> instr_pc sequence 14,15,0 with matching words.
- Redirect in WAIT: redirect=1, redirect_pc=9, during WAIT of addr 3 -> word from addr 3 never appears. Next instr_valid carries instr_pc=9, ROM[9].
- Halt: ROM[2]=0xFF -> 0xFF presented with instr_pc=2; after accept halted=1, mem_cs stays 0 for 20 cycles. Then redirect to 0 -> halted=0, fetch resumes at addr 0.
- Async reset mid-OUT: rst_n low between edges -> instr_valid, mem_cs and halted drop immediately, mem_addr=RESET_PC. After release with run=1, the first instr_pc is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding a decoder from a synchronous program ROM
// Ports: clk/rst_n clock and async active-low reset; run fetch enable;
//        mem_cs/mem_addr/mem_data ROM request and registered read data;
//        instr/instr_pc/instr_valid/instr_ready decoder handshake;
//        redirect/redirect_pc PC jump that squashes in-flight work; halted halt status.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_cs,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, HALTED} state_t;
    state_t state, nxt;
    logic [ADDR_W-1:0] pc, issued_pc;
    // instr_valid and halted are pure state decodes, so redirect and reset clear them with the state
    assign mem_cs      = state == ISSUE;
    assign mem_addr    = pc;
    assign instr_valid = state == OUT;
    assign halted      = state == HALTED;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = run ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = OUT;
            OUT:     nxt = !instr_ready ? OUT : instr == HALT_OPCODE ? HALTED : run ? ISSUE : IDLE;
            HALTED:  nxt = HALTED;
            default: nxt = IDLE;
        endcase
        if (redirect) nxt = run ? ISSUE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            issued_pc <= '0;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state <= nxt;
            pc    <= redirect ? redirect_pc : state == ISSUE ? pc + 1'b1 : pc;
            if (state == ISSUE) issued_pc <= pc;
            if (state == WAIT && !redirect) begin
                instr    <= mem_data;
                instr_pc <= issued_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a synchronous ROM model
module tb_fetch_unit;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       run = 0;
    logic       mem_cs;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic [3:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 0;
    logic       redirect = 0;
    logic [3:0] redirect_pc = '0;
    logic       halted;
    logic [7:0] rom [16];
    int total = 0;
    int bad = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_cs) mem_data <= rom[mem_addr];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_w [3];
        logic [3:0] exp_a [3];
        for (int i = 0; i < 16; i++) rom[i] = 8'h40 + 8'(i);
        rom[0] = 8'h11;
        rom[1] = 8'h22;
        rom[2] = 8'h33;
        mem_data = '0;
        #3;
        chk("rst_cs", 32'(mem_cs), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_ipc", 32'(instr_pc), 0);
        tick();
        rst_n = 1;
        run = 1;
        instr_ready = 1;
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("seq_cs_c%0d", c), 32'(mem_cs), 32'(c % 3 == 1));
            chk($sformatf("seq_valid_c%0d", c), 32'(instr_valid), 32'(c % 3 == 0));
            if (c % 3 == 0) begin
                chk($sformatf("seq_instr_c%0d", c), 32'(instr), 32'(exp_w[c/3-1]));
                chk($sformatf("seq_ipc_c%0d", c), 32'(instr_pc), 32'(c/3-1));
            end
        end
        instr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_instr", 32'(instr), 'h33);
            chk("bp_ipc", 32'(instr_pc), 2);
            chk("bp_cs", 32'(mem_cs), 0);
        end
        instr_ready = 1;
        tick();
        chk("bp_rel_valid", 32'(instr_valid), 0);
        chk("bp_rel_cs", 32'(mem_cs), 1);
        chk("bp_rel_addr", 32'(mem_addr), 3);
        tick();
        chk("rw_wait_cs", 32'(mem_cs), 0);
        redirect = 1;
        redirect_pc = 4'd9;
        tick();
        redirect = 0;
        chk("rw_valid", 32'(instr_valid), 0);
        chk("rw_cs", 32'(mem_cs), 1);
        chk("rw_addr", 32'(mem_addr), 9);
        tick(2);
        chk("rw_out_valid", 32'(instr_valid), 1);
        chk("rw_out_instr", 32'(instr), 'h49);
        chk("rw_out_ipc", 32'(instr_pc), 9);
        rom[14] = 8'hAE;
        rom[15] = 8'hAF;
        rom[0] = 8'hA0;
        redirect = 1;
        redirect_pc = 4'd14;
        tick();
        redirect = 0;
        chk("wr_cs", 32'(mem_cs), 1);
        chk("wr_addr", 32'(mem_addr), 14);
        exp_w[0] = 8'hAE; exp_w[1] = 8'hAF; exp_w[2] = 8'hA0;
        exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick(2);
            chk($sformatf("wr_valid_%0d", k), 32'(instr_valid), 1);
            chk($sformatf("wr_instr_%0d", k), 32'(instr), 32'(exp_w[k]));
            chk($sformatf("wr_ipc_%0d", k), 32'(instr_pc), 32'(exp_a[k]));
            tick();
            chk($sformatf("wr_next_cs_%0d", k), 32'(mem_cs), 1);
        end
        chk("wr_next_addr", 32'(mem_addr), 1);
        rom[0] = 8'h11;
        rom[2] = 8'hFF;
        tick(2);
        chk("h_pre_instr", 32'(instr), 'h22);
        chk("h_pre_ipc", 32'(instr_pc), 1);
        tick(3);
        chk("h_word_valid", 32'(instr_valid), 1);
        chk("h_word_instr", 32'(instr), 'hFF);
        chk("h_word_ipc", 32'(instr_pc), 2);
        chk("h_word_halted", 32'(halted), 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("h_halted", 32'(halted), 1);
            chk("h_cs", 32'(mem_cs), 0);
            chk("h_valid", 32'(instr_valid), 0);
        end
        redirect = 1;
        redirect_pc = 4'd0;
        tick();
        redirect = 0;
        chk("h_exit_halted", 32'(halted), 0);
        chk("h_exit_cs", 32'(mem_cs), 1);
        chk("h_exit_addr", 32'(mem_addr), 0);
        tick(2);
        chk("h_resume_instr", 32'(instr), 'h11);
        chk("h_resume_ipc", 32'(instr_pc), 0);
        chk("h_resume_valid", 32'(instr_valid), 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_valid", 32'(instr_valid), 0);
        chk("ar_cs", 32'(mem_cs), 0);
        chk("ar_halted", 32'(halted), 0);
        chk("ar_addr", 32'(mem_addr), 0);
        tick();
        rst_n = 1;
        tick();
        chk("ar_issue_cs", 32'(mem_cs), 1);
        chk("ar_issue_addr", 32'(mem_addr), 0);
        tick(2);
        chk("ar_first_valid", 32'(instr_valid), 1);
        chk("ar_first_ipc", 32'(instr_pc), 0);
        chk("ar_first_instr", 32'(instr), 'h11);
        run = 0;
        tick();
        chk("idle_valid", 32'(instr_valid), 0);
        chk("idle_cs", 32'(mem_cs), 0);
        chk("idle_addr", 32'(mem_addr), 1);
        tick(3);
        chk("idle_hold_cs", 32'(mem_cs), 0);
        chk("idle_hold_valid", 32'(instr_valid), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
